// File: rtl/regfile_tagged.sv
// Architectural register file with per-register producer tags, multi-port reads
// with CDB bypass, rename, flush and a registered busy-register count.
module regfile_tagged #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int TAG_W  = 5,
    parameter int NRD    = 2,
    parameter int NCDB   = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [NRD*AW-1:0]      RdAddr,
    output logic [NRD*DATA_W-1:0]  RdData,
    output logic [NRD*TAG_W-1:0]   RdLabel,
    input  logic                   RegWr,
    input  logic [AW-1:0]          WriteAddr,
    input  logic [TAG_W-1:0]       WriteLabel,
    input  logic [NCDB-1:0]        BCEN,
    input  logic [NCDB*TAG_W-1:0]  BClabel,
    input  logic [NCDB*DATA_W-1:0] BCdata,
    input  logic                   Flush,
    output logic [AW-1:0]          BusyCount
);

    logic [DATA_W-1:0] data_q [NREG];
    logic [DATA_W-1:0] data_d [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [TAG_W-1:0]  tag_d  [NREG];
    logic [AW-1:0]     busy_count_q;
    logic [AW-1:0]     busy_count_d;

    // Next state: broadcast owns data, rename then flush override the tag.
    always_comb begin
        busy_count_d = '0;
        for (int r = 0; r < NREG; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
            if (r == 0) begin
                data_d[r] = '0;
                tag_d[r]  = '0;
            end else begin
                // Descending scan so the lowest matching channel is applied last.
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (BCEN[c] && (BClabel[c*TAG_W +: TAG_W] != '0) &&
                        (tag_q[r] == BClabel[c*TAG_W +: TAG_W])) begin
                        data_d[r] = BCdata[c*DATA_W +: DATA_W];
                        tag_d[r]  = '0;
                    end
                end
                if (!Flush && RegWr && (WriteLabel != '0) && (WriteAddr == AW'(r))) begin
                    tag_d[r] = WriteLabel;
                end
                if (Flush) begin
                    tag_d[r] = '0;
                end
            end
            if (tag_d[r] != '0) begin
                busy_count_d = busy_count_d + AW'(1);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (RST) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            busy_count_q <= busy_count_d;
        end
    end

    assign BusyCount = busy_count_q;

    // Read ports observe pre-update state, bypassing a matching broadcast.
    always_comb begin
        RdData  = '0;
        RdLabel = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0]     addr;
            logic [DATA_W-1:0] rd_data;
            logic [TAG_W-1:0]  rd_tag;
            addr    = RdAddr[k*AW +: AW];
            rd_data = '0;
            rd_tag  = '0;
            if ((addr != '0) && (int'(addr) < NREG)) begin
                rd_data = data_q[addr];
                rd_tag  = tag_q[addr];
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if ((tag_q[addr] != '0) && BCEN[c] &&
                        (BClabel[c*TAG_W +: TAG_W] == tag_q[addr])) begin
                        rd_data = BCdata[c*DATA_W +: DATA_W];
                        rd_tag  = '0;
                    end
                end
            end
            RdData[k*DATA_W +: DATA_W] = rd_data;
            RdLabel[k*TAG_W +: TAG_W]  = rd_tag;
        end
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Scoreboard bench for regfile_tagged: a behavioural register/tag model predicts
// read-port and BusyCount values that a separate monitor compares against the DUT.
module tb_regfile_tagged;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int TAG_W  = 5;
    localparam int NRD    = 2;
    localparam int NCDB   = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   RST;
    logic [NRD*AW-1:0]      RdAddr;
    logic [NRD*DATA_W-1:0]  RdData;
    logic [NRD*TAG_W-1:0]   RdLabel;
    logic                   RegWr;
    logic [AW-1:0]          WriteAddr;
    logic [TAG_W-1:0]       WriteLabel;
    logic [NCDB-1:0]        BCEN;
    logic [NCDB*TAG_W-1:0]  BClabel;
    logic [NCDB*DATA_W-1:0] BCdata;
    logic                   Flush;
    logic [AW-1:0]          BusyCount;

    regfile_tagged #(.DATA_W(DATA_W), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NCDB(NCDB)) dut (
        .clk(clk), .RST(RST), .RdAddr(RdAddr), .RdData(RdData), .RdLabel(RdLabel),
        .RegWr(RegWr), .WriteAddr(WriteAddr), .WriteLabel(WriteLabel),
        .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .Flush(Flush), .BusyCount(BusyCount)
    );

    always #5 clk = ~clk;

    // Stimulus variables, packed onto the DUT inputs.
    logic        t_rst, t_regwr, t_flush;
    int          t_waddr, t_wlabel;
    logic        t_bcen    [NCDB];
    int          t_bclabel [NCDB];
    logic [31:0] t_bcdata  [NCDB];
    int          t_raddr   [NRD];

    always_comb begin
        RST        = t_rst;
        RegWr      = t_regwr;
        Flush      = t_flush;
        WriteAddr  = AW'(t_waddr);
        WriteLabel = TAG_W'(t_wlabel);
        for (int c = 0; c < NCDB; c++) begin
            BCEN[c]                    = t_bcen[c];
            BClabel[c*TAG_W +: TAG_W]  = TAG_W'(t_bclabel[c]);
            BCdata[c*DATA_W +: DATA_W] = t_bcdata[c];
        end
        for (int k = 0; k < NRD; k++) RdAddr[k*AW +: AW] = AW'(t_raddr[k]);
    end

    // Reference model state
    logic [31:0] m_data [NREG];
    int          m_tag  [NREG];
    int          m_busy;

    typedef struct {
        string       name;
        int          kind;   // 0 read data, 1 read tag, 2 busy count
        int          port;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void push(string name, int kind, int port, logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = exp;
        exp_q.push_back(e);
    endfunction

    // Read semantics: r0 is zero; a pending tag seen on the CDB returns bus data as ready.
    function automatic void model_read(input int a, output logic [31:0] d, output int t);
        d = 32'h0;
        t = 0;
        if (a != 0) begin
            d = m_data[a];
            t = m_tag[a];
            if (m_tag[a] != 0) begin
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (t_bcen[c] && t_bclabel[c] == m_tag[a]) begin
                        d = t_bcdata[c];
                        t = 0;
                    end
                end
            end
        end
    endfunction

    function automatic void model_edge();
        logic [31:0] nd [NREG];
        int          nt [NREG];
        for (int r = 0; r < NREG; r++) begin
            nd[r] = m_data[r];
            nt[r] = m_tag[r];
        end
        if (t_rst) begin
            for (int r = 0; r < NREG; r++) begin
                nd[r] = 32'h0;
                nt[r] = 0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                bit hit = 1'b0;
                for (int c = 0; c < NCDB; c++) begin
                    if (!hit && t_bcen[c] && t_bclabel[c] != 0 && t_bclabel[c] == m_tag[r]) begin
                        nd[r] = t_bcdata[c];
                        nt[r] = 0;
                        hit   = 1'b1;
                    end
                end
                if (!t_flush && t_regwr && t_waddr == r && t_wlabel != 0) nt[r] = t_wlabel;
                if (t_flush) nt[r] = 0;
            end
        end
        m_busy = 0;
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = nd[r];
            m_tag[r]  = nt[r];
            if (r != 0 && nt[r] != 0) m_busy++;
        end
    endfunction

    function automatic void push_reads(string phase);
        logic [31:0] d;
        int          t;
        for (int k = 0; k < NRD; k++) begin
            model_read(t_raddr[k], d, t);
            push($sformatf("%s_rd%0d_data_r%0d", phase, k, t_raddr[k]), 0, k, d);
            push($sformatf("%s_rd%0d_tag_r%0d", phase, k, t_raddr[k]), 1, k, 32'(t));
        end
    endfunction

    // Monitor: compares every queued expectation against the DUT when signalled.
    initial begin
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    0:       act = RdData[e.port*DATA_W +: DATA_W];
                    1:       act = 32'(RdLabel[e.port*TAG_W +: TAG_W]);
                    default: act = 32'(BusyCount);
                endcase
                n_checks++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic idle();
        t_rst = 1'b0; t_regwr = 1'b0; t_flush = 1'b0;
        t_waddr = 0; t_wlabel = 0;
        for (int c = 0; c < NCDB; c++) begin
            t_bcen[c] = 1'b0; t_bclabel[c] = 0; t_bcdata[c] = 32'h0;
        end
    endtask

    // One cycle: inputs are already set (after a rising edge); check reads before and
    // after the falling edge, plus BusyCount after it.
    task automatic cyc();
        #1;
        push_reads("pre");
        ->chk_ev;
        @(negedge clk);
        model_edge();
        #1;
        push_reads("post");
        push("busy", 2, 0, 32'(m_busy));
        ->chk_ev;
        @(posedge clk);
    endtask

    task automatic rd(int a0, int a1);
        t_raddr[0] = a0;
        t_raddr[1] = a1;
    endtask

    task automatic bc(int ch, int lbl, logic [31:0] d);
        t_bcen[ch] = 1'b1; t_bclabel[ch] = lbl; t_bcdata[ch] = d;
    endtask

    task automatic ren(int a, int lbl);
        t_regwr = 1'b1; t_waddr = a; t_wlabel = lbl;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = 32'hX;
            m_tag[r]  = 0;
        end
        m_busy = 0;
        idle();
        rd(0, 0);
        @(posedge clk);

        // Reset, then zero reads and ignored rename of r0
        t_rst = 1'b1;
        #1;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        idle(); rd(5, 0); cyc();
        push("reset_busy", 2, 0, 32'h0); ->chk_ev;
        ren(0, 3); rd(0, 5); cyc();
        idle(); rd(0, 0); cyc();

        // Rename then CDB clear with bypass
        ren(3, 7); rd(3, 1); cyc();
        push("busy_after_rename", 2, 0, 32'h1); ->chk_ev;
        idle(); bc(1, 7, 32'hDEADBEEF); rd(3, 3);
        #1;
        push("bypass_r3_data", 0, 0, 32'hDEADBEEF);
        push("bypass_r3_tag", 1, 0, 32'h0);
        ->chk_ev;
        cyc();
        idle(); rd(3, 3); cyc();
        push("r3_stored", 0, 1, 32'hDEADBEEF); ->chk_ev;

        // One broadcast clears two registers
        ren(4, 2); cyc();
        ren(9, 2); rd(4, 9); cyc();
        idle(); bc(0, 2, 32'h55); rd(4, 9); cyc();
        idle(); rd(4, 9); cyc();

        // Rename wins tag, broadcast wins data
        ren(6, 4); cyc();
        ren(6, 9); bc(0, 4, 32'h11); rd(6, 6); cyc();
        idle(); rd(6, 6); cyc();
        push("r6_tag9", 1, 0, 32'd9); ->chk_ev;

        // Flush with rename and broadcast
        ren(1, 1); cyc();
        ren(2, 2); cyc();
        ren(3, 3); cyc();
        idle(); t_flush = 1'b1; ren(8, 5); bc(0, 2, 32'hAB); rd(2, 8); cyc();
        push("flush_busy", 2, 0, 32'h0); ->chk_ev;
        idle(); rd(1, 3); cyc();
        idle(); rd(2, 8); cyc();

        // Tag-0 broadcast ignored; duplicate-tag broadcast, lowest channel wins
        idle(); bc(0, 0, 32'hFF); bc(1, 0, 32'hFF); rd(4, 9); cyc();
        ren(10, 12); cyc();
        idle(); bc(0, 12, 32'hA0A0); bc(1, 12, 32'hB1B1); rd(10, 10); cyc();
        idle(); rd(10, 4); cyc();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            t_rst   = ($urandom_range(0, 99) == 0);
            t_flush = ($urandom_range(0, 24) == 0);
            t_regwr = $urandom_range(0, 1);
            t_waddr = $urandom_range(0, NREG - 1);
            t_wlabel = $urandom_range(0, 31);
            for (int c = 0; c < NCDB; c++) begin
                t_bcen[c]    = $urandom_range(0, 1);
                t_bclabel[c] = ($urandom_range(0, 9) < 7) ? m_tag[$urandom_range(1, NREG - 1)]
                                                          : int'($urandom_range(0, 31));
                t_bcdata[c]  = $urandom;
            end
            rd($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
            cyc();
        end

        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
